// File: rtl/weight_load_ctrl.sv
// Weight-RAM write-port sequencer: preloads both ping-pong banks on start, then
// refills the freed bank with the next kernel group on each engine request.
module weight_load_ctrl #(
  parameter int DATA_WIDTH      = 16,
  parameter int KERNEL_SIZE_MAX = 3,
  parameter int PARA_KERNEL     = 2,
  parameter int DEPTH_MAX       = 64,
  parameter int WADDR_W         = 7,
  parameter int SRC_ADDR_W      = 16,
  parameter int DEPTH_W         = 8,
  parameter int KNUM_W          = 8
) (
  input  logic                                                       clk,
  input  logic                                                       rst,
  input  logic                                                       start,
  input  logic [DEPTH_W-1:0]                                         fm_depth,
  input  logic [KNUM_W-1:0]                                          kernel_num,
  input  logic                                                       update_weight_ram,
  input  logic [WADDR_W*PARA_KERNEL-1:0]                             update_weight_ram_addr,
  output logic                                                       src_rd_en,
  output logic [SRC_ADDR_W-1:0]                                      src_rd_addr,
  input  logic [KERNEL_SIZE_MAX*KERNEL_SIZE_MAX*PARA_KERNEL*DATA_WIDTH-1:0] src_rd_data,
  input  logic                                                       src_rd_valid,
  output logic [KERNEL_SIZE_MAX*KERNEL_SIZE_MAX*PARA_KERNEL*DATA_WIDTH-1:0] weight_data,
  output logic [WADDR_W*PARA_KERNEL-1:0]                             write_weight_data_addr,
  output logic                                                       weight_wr_en,
  output logic                                                       weight_data_done,
  output logic                                                       all_loaded,
  output logic                                                       req_overflow
);

  localparam int SLICE_W = KERNEL_SIZE_MAX*KERNEL_SIZE_MAX*PARA_KERNEL*DATA_WIDTH;
  localparam int LANES_W = WADDR_W*PARA_KERNEL;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RD_REQ  = 2'd1;
  localparam logic [1:0] ST_RD_WAIT = 2'd2;
  localparam logic [1:0] ST_FIN     = 2'd3;

  localparam logic [DEPTH_W:0]     DEPTH_MAX_C = (DEPTH_W+1)'(DEPTH_MAX);
  localparam logic [KNUM_W:0]      PK_C        = (KNUM_W+1)'(PARA_KERNEL);
  localparam logic [KNUM_W:0]      PK_M1_C     = (KNUM_W+1)'(PARA_KERNEL-1);
  localparam logic [WADDR_W-1:0]   BANK1_BASE  = WADDR_W'(DEPTH_MAX);

  logic [1:0]            state_q, state_d;
  logic [DEPTH_W-1:0]    depth_q, depth_d;
  logic [KNUM_W-1:0]     groups_q, groups_d;
  logic [KNUM_W-1:0]     grp_q, grp_d;
  logic [SRC_ADDR_W-1:0] src_base_q, src_base_d;
  logic [DEPTH_W-1:0]    slice_q, slice_d;
  logic [LANES_W-1:0]    base_q, base_d;
  logic                  init_load_q, init_load_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [LANES_W-1:0]    pend_addr_q, pend_addr_d;
  logic                  overflow_q, overflow_d;
  logic                  started_q, started_d;
  logic [SLICE_W-1:0]    data_q, data_d;
  logic [LANES_W-1:0]    wr_addr_q, wr_addr_d;
  logic                  wr_en_q, wr_en_d;
  logic                  done_q, done_d;

  logic [DEPTH_W-1:0]    depth_cfg;
  logic [KNUM_W-1:0]     groups_cfg;
  logic [KNUM_W-1:0]     kn_eff;
  logic [KNUM_W:0]       kn_sum;
  logic [LANES_W-1:0]    lane_addr;
  logic [WADDR_W-1:0]    slice_w;
  logic                  last_slice;
  logic                  more_groups;

  // Layer configuration derived from the start-time inputs.
  always_comb begin
    if (fm_depth == '0) begin
      depth_cfg = DEPTH_W'(1);
    end else if ({1'b0, fm_depth} > DEPTH_MAX_C) begin
      depth_cfg = DEPTH_W'(DEPTH_MAX);
    end else begin
      depth_cfg = fm_depth;
    end
    kn_eff     = (kernel_num == '0) ? KNUM_W'(1) : kernel_num;
    kn_sum     = {1'b0, kn_eff} + PK_M1_C;
    groups_cfg = KNUM_W'(kn_sum / PK_C);
  end

  assign slice_w     = WADDR_W'(slice_q);
  assign last_slice  = (slice_q == depth_q - DEPTH_W'(1));
  assign more_groups = (grp_q < groups_q);

  generate
    for (genvar gi = 0; gi < PARA_KERNEL; gi++) begin : g_lane
      assign lane_addr[gi*WADDR_W +: WADDR_W] = base_q[gi*WADDR_W +: WADDR_W] + slice_w;
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    depth_d      = depth_q;
    groups_d     = groups_q;
    grp_d        = grp_q;
    src_base_d   = src_base_q;
    slice_d      = slice_q;
    base_d       = base_q;
    init_load_d  = init_load_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    overflow_d   = overflow_q;
    started_d    = started_q;
    data_d       = data_q;
    wr_addr_d    = wr_addr_q;
    wr_en_d      = 1'b0;
    done_d       = done_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_RD_REQ;
          depth_d      = depth_cfg;
          groups_d     = groups_cfg;
          grp_d        = '0;
          src_base_d   = '0;
          slice_d      = '0;
          base_d       = '0;
          init_load_d  = 1'b1;
          pend_valid_d = 1'b0;
          pend_addr_d  = '0;
          overflow_d   = 1'b0;
          started_d    = 1'b1;
          done_d       = 1'b0;
        end else if (pend_valid_q) begin
          // A request arriving while the slot drains simply takes its place.
          pend_valid_d = update_weight_ram;
          if (update_weight_ram) begin
            pend_addr_d = update_weight_ram_addr;
          end
          if (more_groups) begin
            state_d     = ST_RD_REQ;
            base_d      = pend_addr_q;
            init_load_d = 1'b0;
            done_d      = 1'b0;
          end
        end else if (update_weight_ram && more_groups) begin
          state_d     = ST_RD_REQ;
          base_d      = update_weight_ram_addr;
          init_load_d = 1'b0;
          done_d      = 1'b0;
        end
      end
      ST_RD_REQ: begin
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (src_rd_valid) begin
          data_d    = src_rd_data;
          wr_addr_d = lane_addr;
          wr_en_d   = 1'b1;
          if (last_slice) begin
            slice_d    = '0;
            grp_d      = grp_q + KNUM_W'(1);
            src_base_d = src_base_q + SRC_ADDR_W'(depth_q);
            if (init_load_q && (groups_q > KNUM_W'(1))) begin
              base_d      = {PARA_KERNEL{BANK1_BASE}};
              init_load_d = 1'b0;
              state_d     = ST_RD_REQ;
            end else begin
              state_d = ST_FIN;
            end
          end else begin
            slice_d = slice_q + DEPTH_W'(1);
            state_d = ST_RD_REQ;
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        // Stay low when a queued refill is about to start another load.
        done_d  = !((pend_valid_q || update_weight_ram) && more_groups);
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if ((state_q != ST_IDLE) && update_weight_ram) begin
      if (pend_valid_q) begin
        overflow_d = 1'b1;
      end else begin
        pend_valid_d = 1'b1;
        pend_addr_d  = update_weight_ram_addr;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      depth_q      <= '0;
      groups_q     <= '0;
      grp_q        <= '0;
      src_base_q   <= '0;
      slice_q      <= '0;
      base_q       <= '0;
      init_load_q  <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      overflow_q   <= 1'b0;
      started_q    <= 1'b0;
      data_q       <= '0;
      wr_addr_q    <= '0;
      wr_en_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      depth_q      <= depth_d;
      groups_q     <= groups_d;
      grp_q        <= grp_d;
      src_base_q   <= src_base_d;
      slice_q      <= slice_d;
      base_q       <= base_d;
      init_load_q  <= init_load_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      overflow_q   <= overflow_d;
      started_q    <= started_d;
      data_q       <= data_d;
      wr_addr_q    <= wr_addr_d;
      wr_en_q      <= wr_en_d;
      done_q       <= done_d;
    end
  end

  assign src_rd_en              = (state_q == ST_RD_REQ);
  assign src_rd_addr            = src_base_q + SRC_ADDR_W'(slice_q);
  assign weight_data            = data_q;
  assign write_weight_data_addr = wr_addr_q;
  assign weight_wr_en           = wr_en_q;
  assign weight_data_done       = done_q;
  assign all_loaded             = started_q && (grp_q == groups_q);
  assign req_overflow           = overflow_q;

endmodule

// File: doc/weight_load_ctrl.md
# weight_load_ctrl

Sequencer that owns the weight-RAM write port of the float16 CNN layer engine. On a layer start it preloads the first two kernel groups into the ping-pong weight banks. Each subsequent `update_weight_ram` request from the engine refills the freed bank with the next kernel group, fetched slice by slice from an external weight buffer. It replaces the hand-driven weight loading currently done from the test bench and sits between the weight buffer and the layer engine's `weight_data` / `write_weight_data_addr` / `weight_data_done` inputs.

## Interface
Parameters:
- `DATA_WIDTH`, 16: float16 word width.
- `KERNEL_SIZE_MAX`, 3: max kernel edge; one slice per kernel is `KERNEL_SIZE_MAX*KERNEL_SIZE_MAX` words.
- `PARA_KERNEL`, 2: kernels per group, loaded in parallel.
- `DEPTH_MAX`, 64: bank size in slices; bank 1 base address is `DEPTH_MAX`.
- `WADDR_W`, 7: per-kernel weight RAM address width; must satisfy `2*DEPTH_MAX-1 < 2^WADDR_W`.
- `SRC_ADDR_W`, 16: weight buffer address width.
- `DEPTH_W`, 8: width of `fm_depth`.
- `KNUM_W`, 8: width of `kernel_num`.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse; latch config and begin the initial load.
- `fm_depth` in DEPTH_W: slices per kernel.
- `kernel_num` in KNUM_W: kernels in the layer.
- `update_weight_ram` in 1: one-cycle refill request from the engine.
- `update_weight_ram_addr` in WADDR_W*PARA_KERNEL: per-lane base address of the bank to refill.
- `src_rd_en` out 1: one-cycle read request to the weight buffer.
- `src_rd_addr` out SRC_ADDR_W: slice index to read.
- `src_rd_data` in KERNEL_SIZE_MAX²·PARA_KERNEL·DATA_WIDTH: one slice for all lanes.
- `src_rd_valid` in 1: `src_rd_data` is valid this cycle.
- `weight_data` out same width as `src_rd_data`: slice to write.
- `write_weight_data_addr` out WADDR_W*PARA_KERNEL: per-lane write address.
- `weight_wr_en` out 1: write strobe; one cycle per slice.
- `weight_data_done` out 1: level; high means the banks are consistent and the controller is idle.
- `all_loaded` out 1: every kernel group of the layer has been fetched.
- `req_overflow` out 1: sticky; set when a refill request is dropped.

## Operation
Configuration latched on `start`:
- `depth = (fm_depth==0) ? 1 : min(fm_depth, DEPTH_MAX)`.
- `groups = ceil(kernel_num/PARA_KERNEL)`; a `kernel_num` of 0 is treated as 1.

Counters:
- `slice` runs 0..depth-1.
- `grp` counts groups fetched.
- `src_base` advances by `depth` per group (accumulator; no multiplier).
- `src_rd_addr = src_base + slice`.

FSM states: IDLE, RD_REQ, RD_WAIT, FIN.
- IDLE → RD_REQ on `start`; the initial load targets bank 0, with all lanes at base 0.
- IDLE → RD_REQ on a refill request (new or pending) if `grp < groups`; the lane bases come from the request.
- A refill request in IDLE with `grp == groups` performs no reads. `weight_data_done` stays 1.
- RD_REQ: assert `src_rd_en` for one cycle, then go to RD_WAIT.
- RD_WAIT: hold until `src_rd_valid`. On that cycle register the data; `write_weight_data_addr` lane k becomes `base_k + slice`.
  - More slices remain: increment `slice`, go to RD_REQ.
  - Last slice: increment `grp`, add `depth` to `src_base`, clear `slice`.
  - Next state after the last slice: if this was the bank-0 initial load and `groups > 1`, retarget all lanes to base `DEPTH_MAX` and go to RD_REQ. Otherwise go to FIN.
- FIN: set `weight_data_done`, go to IDLE.

Boundary rules:
- `weight_data_done` clears in the cycle after `start` or after an accepted refill request. It rises only in FIN.
- `all_loaded` = (`grp == groups`) after the first `start`.
- A refill request while not IDLE is stored in a one-deep pending slot (with its address) and serviced from IDLE on the next cycle. `weight_data_done` stays low across back-to-back loads.
- A request while the pending slot is full is dropped and sets `req_overflow`.
- `start` while not IDLE is ignored. `start` in IDLE clears `grp`, `src_base`, the pending slot and `req_overflow`.
- `src_rd_valid` outside RD_WAIT is ignored.

## Timing
- Reset values: all outputs 0. The FSM goes to IDLE and all counters and the pending slot clear.
- Per slice: `src_rd_en` at cycle t; `src_rd_valid` at t+L (L ≥ 1); `weight_wr_en`, `weight_data` and the address are visible at t+L+1.
- The next `src_rd_en` is asserted at t+L+1, in the same cycle as that write.
- `weight_data_done` rises 1 cycle after the last `weight_wr_en`.
- Refill latency: request at cycle r → `src_rd_en` at r+1.
- Reset mid-load aborts immediately. No `weight_wr_en` is issued afterwards, even if a stale `src_rd_valid` arrives.

## Test plan
- Initial load: `start` with `fm_depth=2`, `kernel_num=6`, L=2.
  - Expect `src_rd_addr` 0,1,2,3.
  - Expect write addresses 0, 1, DEPTH_MAX, DEPTH_MAX+1 on all lanes.
  - Expect `weight_data_done` to rise 1 cycle after the 4th `weight_wr_en`, with `all_loaded=0`.
- Refill: then request `update_weight_ram` with base 0 on both lanes.
  - Expect `weight_data_done`=0 the next cycle and reads at `src_rd_addr` 4,5.
  - Expect writes to address 0,1 and `done`=1, with `all_loaded=1`.
- Refill after exhaustion: a further request produces no `src_rd_en` and no writes. `weight_data_done` stays 1.
- Requests during the initial load:
  - One request: it is serviced right after the initial load. `weight_data_done` never pulses high in between.
  - A second request in the same load is dropped and sets `req_overflow=1`.
- Single group: `kernel_num=1`, `fm_depth=0`. Expect exactly one read (addr 0), one write to address 0, `done`=1 and `all_loaded=1`.
- Reset mid-load: assert `rst` during RD_WAIT, then deliver `src_rd_valid`. All outputs stay 0 and no `weight_wr_en` is issued.
